// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: default widths, ALU op codes and
// the sequencer state type.
package alu_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_CODE_W = 4;

    localparam logic [3:0] ALU_OP_NOP = 4'b0000;
    localparam logic [3:0] ALU_OP_ADD = 4'b1000;
    localparam logic [3:0] ALU_OP_SUB = 4'b0100;
    localparam logic [3:0] ALU_OP_BEQ = 4'b1100;
    localparam logic [3:0] ALU_OP_BLT = 4'b1101;
    localparam logic [3:0] ALU_OP_BGT = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way winner selection for the ALU arbiter. Round-robin by default;
// ALU_ARB_FIXED_PRIO_EN makes requester 0 always win simultaneous requests.
module alu_rr_pick (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       winner_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        winner_id = ~req[0];
    end
`else
    // On contention the requester that did not win last time goes next.
    always_comb begin
        if (req == 2'b11) begin
            winner_id = ~last_grant;
        end else begin
            winner_id = req[1];
        end
    end
`endif

    always_comb begin
        grant = 2'b00;
        if (req != 2'b00) begin
            grant = winner_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer in front of the shared combinational ALU:
// accept -> one EXEC cycle -> hold response. Build option: ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int CODE_W = ALU_CODE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*CODE_W-1:0]   req_code,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_W-1:0]     resp_accum,
    output logic                  resp_branch,
    output logic [CODE_W-1:0]     alu_code,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic [DATA_W-1:0]     alu_accum,
    input  logic                  alu_branch
);

    arb_state_t state_q, state_d;

    logic              last_grant_q, last_grant_d;
    logic [CODE_W-1:0] op_code_q, op_code_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              op_id_q, op_id_d;
    logic              resp_id_q, resp_id_d;
    logic [DATA_W-1:0] resp_accum_q, resp_accum_d;
    logic              resp_branch_q, resp_branch_d;

    logic [1:0] pick_grant;
    logic       pick_id;
    logic       accept;

    alu_rr_pick u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .winner_id  (pick_id)
    );

    assign accept = (state_q == IDLE) && (req_valid != 2'b00);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; the ALU sees code 0 (its default case) outside EXEC.
    always_comb begin
        req_ready  = 2'b00;
        resp_valid = 1'b0;
        alu_code   = '0;
        alu_a      = '0;
        alu_b      = '0;
        case (state_q)
            IDLE: if (!rst) req_ready = pick_grant;
            EXEC: begin
                alu_code = op_code_q;
                alu_a    = op_a_q;
                alu_b    = op_b_q;
            end
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand latch on accept, result capture at the end of EXEC
    always_comb begin
        last_grant_d  = last_grant_q;
        op_code_d     = op_code_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_id_d       = op_id_q;
        resp_id_d     = resp_id_q;
        resp_accum_d  = resp_accum_q;
        resp_branch_d = resp_branch_q;
        if (accept) begin
            last_grant_d = pick_id;
            op_id_d      = pick_id;
            op_code_d    = pick_id ? req_code[2*CODE_W-1:CODE_W] : req_code[CODE_W-1:0];
            op_a_d       = pick_id ? req_a[2*DATA_W-1:DATA_W]    : req_a[DATA_W-1:0];
            op_b_d       = pick_id ? req_b[2*DATA_W-1:DATA_W]    : req_b[DATA_W-1:0];
        end
        if (state_q == EXEC) begin
            resp_id_d     = op_id_q;
            resp_accum_d  = alu_accum;
            resp_branch_d = alu_branch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q  <= 1'b1;
            op_code_q     <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_id_q       <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_accum_q  <= '0;
            resp_branch_q <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            op_code_q     <= op_code_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_id_q       <= op_id_d;
            resp_id_q     <= resp_id_d;
            resp_accum_q  <= resp_accum_d;
            resp_branch_q <= resp_branch_d;
        end
    end

    assign resp_id     = resp_id_q;
    assign resp_accum  = resp_accum_q;
    assign resp_branch = resp_branch_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU attached and an
// op-level reference model (expected winner and result per transaction).
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DW = 16;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [2*CW-1:0] req_code = '0;
    logic [2*DW-1:0] req_a = '0;
    logic [2*DW-1:0] req_b = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b1;
    logic            resp_id;
    logic [DW-1:0]   resp_accum;
    logic            resp_branch;
    logic [CW-1:0]   alu_code;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [DW-1:0]   alu_accum;
    logic            alu_branch;

    int   errors = 0;
    int   checks = 0;
    logic model_last = 1'b1;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_code    (req_code),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_accum  (resp_accum),
        .resp_branch (resp_branch),
        .alu_code    (alu_code),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_accum   (alu_accum),
        .alu_branch  (alu_branch)
    );

    // Returns {branch, accum} for one ALU operation
    function automatic logic [DW:0] alu_fn(input logic [CW-1:0] c, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (c)
            ALU_OP_ADD: begin r = a + b; return {1'b0, r}; end
            ALU_OP_SUB: begin r = a - b; return {1'b0, r}; end
            ALU_OP_BEQ: return {(a == b), {DW{1'b0}}};
            ALU_OP_BLT: return {(a < b), {DW{1'b0}}};
            ALU_OP_BGT: return {(a > b), {DW{1'b0}}};
            default:    return '0;
        endcase
    endfunction

    always_comb {alu_branch, alu_accum} = alu_fn(alu_code, alu_a, alu_b);

    function automatic int exp_winner(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 0;
`else
        return model_last ? 0 : 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_payload(input int id, input logic [CW-1:0] c, input logic [DW-1:0] a,
                               input logic [DW-1:0] b);
        if (id == 0) begin
            req_code[CW-1:0] = c; req_a[DW-1:0] = a; req_b[DW-1:0] = b;
        end else begin
            req_code[2*CW-1:CW] = c; req_a[2*DW-1:DW] = a; req_b[2*DW-1:DW] = b;
        end
    endtask

    // One complete transaction from IDLE with resp_ready high; payloads already set.
    task automatic run_op(input string tag, input logic [1:0] mask,
                          input logic [CW-1:0] c0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                          input logic [CW-1:0] c1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
        int w;
        logic [CW-1:0] c; logic [DW-1:0] a, b;
        logic [DW:0] res;
        set_payload(0, c0, a0, b0);
        set_payload(1, c1, a1, b1);
        req_valid = mask;
        w = exp_winner(mask);
        c = (w == 0) ? c0 : c1; a = (w == 0) ? a0 : a1; b = (w == 0) ? b0 : b1;
        res = alu_fn(c, a, b);
        #1;
        check({tag, ".ready"}, 32'(req_ready), 32'(2'b01 << w));
        tick();
        req_valid = 2'b00;
        model_last = w[0];
        check({tag, ".exec_code"}, 32'(alu_code), 32'(c));
        check({tag, ".exec_rv"}, 32'(resp_valid), 32'd0);
        tick();
        check({tag, ".rv"}, 32'(resp_valid), 32'd1);
        check({tag, ".id"}, 32'(resp_id), 32'(w));
        check({tag, ".accum"}, 32'(resp_accum), 32'(res[DW-1:0]));
        check({tag, ".branch"}, 32'(resp_branch), 32'(res[DW]));
        tick();
        check({tag, ".idle_rv"}, 32'(resp_valid), 32'd0);
    endtask

    logic [CW-1:0] code_tbl [7];

    initial begin
        code_tbl = '{ALU_OP_ADD, ALU_OP_SUB, ALU_OP_BEQ, ALU_OP_BLT, ALU_OP_BGT, 4'b0011, ALU_OP_NOP};

        // Reset state, with requests pending to show req_ready is held low
        req_valid = 2'b11;
        #12;
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.rv", 32'(resp_valid), 32'd0);
        check("rst.payload", {resp_id, resp_branch, resp_accum}, 32'd0);
        check("rst.alu", {alu_code, alu_a}, 32'd0);
        req_valid = 2'b00;
        tick();
        rst = 1'b0;
        tick();

        // Directed single ops
        run_op("add", 2'b01, ALU_OP_ADD, 16'h0003, 16'h0004, 4'h0, 16'h0, 16'h0);
        check("add.value", 32'(resp_accum), 32'h0007);
        run_op("sub_wrap", 2'b10, 4'h0, 16'h0, 16'h0, ALU_OP_SUB, 16'h0000, 16'h0001);
        check("sub_wrap.value", 32'(resp_accum), 32'hFFFF);
        run_op("blt", 2'b10, 4'h0, 16'h0, 16'h0, ALU_OP_BLT, 16'h0001, 16'h0002);
        check("blt.value", {15'd0, resp_branch, resp_accum}, 32'h0001_0000);
        run_op("bgt", 2'b10, 4'h0, 16'h0, 16'h0, ALU_OP_BGT, 16'h0001, 16'h0002);
        check("bgt.value", {15'd0, resp_branch, resp_accum}, 32'h0);
        run_op("undef", 2'b01, 4'b0011, 16'h1234, 16'h0001, 4'h0, 16'h0, 16'h0);
        check("undef.value", {15'd0, resp_branch, resp_accum}, 32'h0);

        // Contention: both valid the whole time
        set_payload(0, ALU_OP_ADD, 16'd10, 16'd20);
        set_payload(1, ALU_OP_SUB, 16'd100, 16'd1);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = exp_winner(2'b11);
            #1;
            check($sformatf("cont%0d.ready", k), 32'(req_ready), 32'(2'b01 << w));
            tick();
            model_last = w[0];
            tick();
            check($sformatf("cont%0d.id", k), 32'(resp_id), 32'(w));
            check($sformatf("cont%0d.accum", k), 32'(resp_accum), (w == 0) ? 32'd30 : 32'd99);
            tick();
        end
        req_valid = 2'b00;
        tick();

        // Backpressure: 5 cycles of resp_ready low while requester 1 waits
        resp_ready = 1'b0;
        set_payload(0, ALU_OP_ADD, 16'd5, 16'd6);
        set_payload(1, ALU_OP_ADD, 16'h00FF, 16'h0001);
        req_valid = 2'b01;
        tick();
        model_last = 1'b0;
        req_valid = 2'b10;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d.rv", i), 32'(resp_valid), 32'd1);
            check($sformatf("bp%0d.payload", i), {15'd0, resp_id, resp_accum}, 32'd11);
            check($sformatf("bp%0d.ready", i), 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("bp.hs_rv", 32'(resp_valid), 32'd1);
        check("bp.hs_ready", 32'(req_ready), 32'd0);
        tick();
        check("bp.idle_rv", 32'(resp_valid), 32'd0);
        check("bp.idle_ready", 32'(req_ready), 32'b10);
        tick();
        model_last = 1'b1;
        req_valid = 2'b00;
        tick();
        check("bp.second", {15'd0, resp_id, resp_accum}, 32'h0001_0100);
        tick();

        // Reset during EXEC discards the op
        set_payload(0, ALU_OP_ADD, 16'd1, 16'd1);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check("rexec.code", 32'(alu_code), 32'(ALU_OP_ADD));
        #2 rst = 1'b1;
        #1;
        check("rexec.alu", {alu_code, alu_a}, 32'd0);
        check("rexec.rv", 32'(resp_valid), 32'd0);
        check("rexec.payload", {resp_id, resp_branch, resp_accum}, 32'd0);
        model_last = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rexec.norsp%0d", i), 32'(resp_valid), 32'd0);
        end
        run_op("post_rst", 2'b11, ALU_OP_BEQ, 16'h0042, 16'h0042, ALU_OP_ADD, 16'd7, 16'd8);
        check("post_rst.grant0", 32'(resp_id), 32'd0);

        // Randomized ops against the model
        for (int n = 0; n < 24; n++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            run_op($sformatf("rnd%0d", n), m,
                   code_tbl[$urandom_range(0, 6)], 16'($urandom), 16'($urandom),
                   code_tbl[$urandom_range(0, 6)], 16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 16-bit ALU. Each requester presents an ALU operation with a valid/ready handshake. The block grants one requester at a time, drives the registered operation into the combinational ALU for exactly one cycle, and captures the ALU's accumulator and branch outputs. It returns the captured result on a single response channel tagged with the requester ID. It sits between the fetch/decode front-end (requester 0) and the branch-resolution unit (requester 1) on one side, and the ALU instance on the other.

## Interface
- DATA_W, 16, operand/result width
- CODE_W, 4, ALU operation code width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; one-hot or zero
- req_code  in  2*CODE_W  per-requester op code; requester i at [i*CODE_W +: CODE_W]
- req_a  in  2*DATA_W  per-requester operand 1
- req_b  in  2*DATA_W  per-requester operand 2
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  1  requester that issued the op
- resp_accum  out  DATA_W  captured ALU accumulator
- resp_branch  out  1  captured ALU branch_check
- alu_code  out  CODE_W  to ALU alu_code
- alu_a  out  DATA_W  to ALU reg_data1
- alu_b  out  DATA_W  to ALU reg_data2
- alu_accum  in  DATA_W  from ALU accum
- alu_branch  in  1  from ALU branch_check

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid bit is set, pick a winner and assert req_ready[winner] combinationally in the same cycle.
  - Latch code, A, B and winner ID, then go to EXEC.
  - With no request, stay in IDLE.
- EXEC (exactly one cycle):
  - Drive alu_code/alu_a/alu_b from the latched registers.
  - At the end of the cycle, capture alu_accum and alu_branch into the response registers, then go to RESP.
- RESP:
  - Hold resp_valid high with stable resp_id, resp_accum and resp_branch until resp_ready is high.
  - On handshake, go to IDLE.
  - No request is accepted in RESP or EXEC; req_ready = 0 in both.
- Arbitration is round-robin:
  - A last_grant register starts at 1, so requester 0 wins the first contention.
  - When both requesters are valid, the winner is the requester not in last_grant.
  - When one is valid, it wins.
  - last_grant updates on every accept.
- Outside EXEC, alu_code, alu_a and alu_b are driven to 0. Code 0 is the ALU's default case, so the ALU then outputs accum = 0 and branch_check = 0.
- Op codes pass through unchecked:
  - Undefined codes return accum = 0, branch = 0.
  - ADD/SUB wrap modulo 2^DATA_W.
  - Compare codes return accum = 0 with branch set per the ALU.
- A requester must hold req_valid and its payload stable until accepted. A dropped request is simply not served.

## Timing
- Reset values: state = IDLE, last_grant = 1, req_ready = 0, resp_valid = 0, resp_id = 0, resp_accum = 0, resp_branch = 0, alu_code/alu_a/alu_b = 0.
- Accept in cycle N, EXEC in N+1, resp_valid first high in N+2.
- With resp_ready tied high, the response handshakes in N+2, IDLE is in N+3, and the next accept can occur in N+3. Peak throughput is one op per 3 cycles.
- Backpressure: resp_valid stays high indefinitely while resp_ready is low, and payload is unchanged.
- Reset asserted mid-operation clears all state immediately (asynchronous). The in-flight op is discarded and no response is produced.
- resp_ready high while resp_valid is low has no effect.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - Defined: requester 0 always wins simultaneous requests, and last_grant is unused (may be optimised out).
  - Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

## Structure
- Shared package alu_pkg holds:
  - op code constants ALU_OP_ADD = 4'b1000, ALU_OP_SUB = 4'b0100, ALU_OP_BEQ = 4'b1100, ALU_OP_BLT = 4'b1101, ALU_OP_BGT = 4'b1110, ALU_OP_NOP = 4'b0000;
  - the FSM state typedef arb_state_t (IDLE, EXEC, RESP);
  - the default DATA_W/CODE_W.
- One sub-module, alu_rr_pick:
  - inputs: 2-bit request, last_grant;
  - outputs: one-hot grant, winner ID;
  - contains the ALU_ARB_FIXED_PRIO_EN switch.
- The ALU itself is instantiated at the top level, not inside this block.

## Test plan
- Single op: requester 0 sends ADD 0x0003 + 0x0004 -> req_ready[0] in the accept cycle; resp_valid 2 cycles later with resp_id = 0, accum = 0x0007, branch = 0.
- Wrap and compare: requester 1 sends SUB 0x0000 - 0x0001 -> accum = 0xFFFF. BLT 0x0001, 0x0002 -> accum = 0, branch = 1. BGT with the same operands -> branch = 0.
- Contention: both requesters valid continuously with distinct ops -> grants alternate 0, 1, 0, 1, matching resp_id. With ALU_ARB_FIXED_PRIO_EN defined -> all grants go to 0 while it stays valid.
- Backpressure: resp_ready low for 5 cycles after resp_valid -> payload stable, req_ready = 0 throughout. Handshake on cycle 6, IDLE on cycle 7.
- Reset mid-EXEC: assert rst during EXEC -> all outputs return to reset values in the same cycle, no response appears, and the first post-reset contention grants requester 0.
- Undefined code 4'b0011 with A = 0x1234, B = 0x0001 -> accum = 0, branch = 0, normal 3-cycle latency.
